// File: rtl/duv_mem_arb_if.sv
// Bus bundle for duv_mem_arb: requester handshake, read return and registered memory port.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface duv_mem_arb_if #(
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 32
) ();
  logic [REQUESTERS-1:0]    mem_arb_req_ip;
  logic [REQUESTERS-1:0]    mem_arb_lock_ip;
  logic [REQUESTERS-1:0]    mem_arb_we_ip;
  logic [REQUESTERS*AW-1:0] mem_arb_addr_ip;
  logic [REQUESTERS*DW-1:0] mem_arb_wdata_ip;
  logic [REQUESTERS-1:0]    mem_arb_gnt_op;
  logic [REQUESTERS-1:0]    mem_arb_rvalid_op;
  logic [DW-1:0]            mem_arb_rdata_op;
  logic                     mem_arb_mem_en_op;
  logic                     mem_arb_mem_we_op;
  logic [AW-1:0]            mem_arb_mem_addr_op;
  logic [DW-1:0]            mem_arb_mem_wdata_op;
  logic [DW-1:0]            mem_arb_mem_rdata_ip;

  modport slave (
    input  mem_arb_req_ip, mem_arb_lock_ip, mem_arb_we_ip, mem_arb_addr_ip, mem_arb_wdata_ip,
    input  mem_arb_mem_rdata_ip,
    output mem_arb_gnt_op, mem_arb_rvalid_op, mem_arb_rdata_op,
    output mem_arb_mem_en_op, mem_arb_mem_we_op, mem_arb_mem_addr_op, mem_arb_mem_wdata_op
  );

  modport master (
    output mem_arb_req_ip, mem_arb_lock_ip, mem_arb_we_ip, mem_arb_addr_ip, mem_arb_wdata_ip,
    output mem_arb_mem_rdata_ip,
    input  mem_arb_gnt_op, mem_arb_rvalid_op, mem_arb_rdata_op,
    input  mem_arb_mem_en_op, mem_arb_mem_we_op, mem_arb_mem_addr_op, mem_arb_mem_wdata_op
  );
endinterface

// File: rtl/duv_mem_arb.sv
// Round-robin arbiter with bounded grant locking in front of a single-port memory.
// Optional per-requester grant/wait statistics when EXM_MEM_ARB_STATS_EN is defined.
module duv_mem_arb #(
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 32,
  parameter int unsigned MAX_LOCK   = 8
) (
  input logic          mem_arb_clk_ip,
  input logic          mem_arb_rst_ip,
  duv_mem_arb_if.slave bus
);
  localparam int unsigned IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int unsigned CW = 8;
  localparam logic [IW-1:0] LastIdx = IW'(REQUESTERS - 1);
  localparam logic [CW-1:0] MaxLock = CW'(MAX_LOCK);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          owner_vld_q, owner_vld_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  logic [REQUESTERS-1:0] gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  gnt_any;
  logic                  lock_hit;
  logic [IW-1:0]         scan_idx;
  logic [AW-1:0]         addr_sel;
  logic [DW-1:0]         wdata_sel;
  logic                  we_sel;

  logic                  mem_en_q, mem_we_q;
  logic [AW-1:0]         mem_addr_q;
  logic [DW-1:0]         mem_wdata_q;
  logic                  rd_pend_q;
  logic [IW-1:0]         rd_id_q;
  logic [REQUESTERS-1:0] rvalid_q;
  logic [DW-1:0]         rdata_q;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    lock_hit = 1'b0;
    scan_idx = ptr_q;
    if (!mem_arb_rst_ip) begin
      if (owner_vld_q && bus.mem_arb_req_ip[owner_q] && (lock_cnt_q < MaxLock)) begin
        lock_hit = 1'b1;
        gnt_any  = 1'b1;
        gnt_idx  = owner_q;
      end else begin
        for (int unsigned k = 0; k < REQUESTERS; k++) begin
          if (!gnt_any && bus.mem_arb_req_ip[scan_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_idx;
          end
          scan_idx = (scan_idx == LastIdx) ? '0 : scan_idx + IW'(1);
        end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      if (gnt_idx == IW'(k)) begin
        addr_sel  = bus.mem_arb_addr_ip[k*AW +: AW];
        wdata_sel = bus.mem_arb_wdata_ip[k*DW +: DW];
        we_sel    = bus.mem_arb_we_ip[k];
      end
    end
  end

  // A lock only continues while granted through lock_hit; a rotation win restarts the count.
  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    lock_cnt_d  = lock_cnt_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + IW'(1);
      if (bus.mem_arb_lock_ip[gnt_idx]) begin
        owner_vld_d = 1'b1;
        owner_d     = gnt_idx;
        lock_cnt_d  = lock_hit ? lock_cnt_q + CW'(1) : CW'(1);
      end else begin
        owner_vld_d = 1'b0;
        lock_cnt_d  = '0;
      end
    end else if (owner_vld_q && !bus.mem_arb_req_ip[owner_q]) begin
      owner_vld_d = 1'b0;
      lock_cnt_d  = '0;
    end
  end

  always_ff @(posedge mem_arb_clk_ip or posedge mem_arb_rst_ip) begin
    if (mem_arb_rst_ip) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      lock_cnt_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end

  always_ff @(posedge mem_arb_clk_ip or posedge mem_arb_rst_ip) begin
    if (mem_arb_rst_ip) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_id_q     <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      mem_en_q  <= gnt_any;
      mem_we_q  <= gnt_any && we_sel;
      rd_pend_q <= gnt_any && !we_sel;
      rd_id_q   <= gnt_idx;
      if (gnt_any) begin
        mem_addr_q  <= addr_sel;
        mem_wdata_q <= wdata_sel;
      end
      rvalid_q <= '0;
      if (rd_pend_q) rvalid_q[rd_id_q] <= 1'b1;
      if (|rvalid_q) rdata_q <= bus.mem_arb_mem_rdata_ip;
    end
  end

  // Read data is the memory's output during the rvalid cycle and holds afterwards.
  assign bus.mem_arb_gnt_op       = gnt;
  assign bus.mem_arb_rvalid_op    = rvalid_q;
  assign bus.mem_arb_rdata_op     = (|rvalid_q) ? bus.mem_arb_mem_rdata_ip : rdata_q;
  assign bus.mem_arb_mem_en_op    = mem_en_q;
  assign bus.mem_arb_mem_we_op    = mem_we_q;
  assign bus.mem_arb_mem_addr_op  = mem_addr_q;
  assign bus.mem_arb_mem_wdata_op = mem_wdata_q;

`ifdef EXM_MEM_ARB_STATS_EN
`ifndef EXM_VLTOR_PUBLIC_RD
`define EXM_VLTOR_PUBLIC_RD
`endif
`ifndef EXM_INFORMATION
`define EXM_INFORMATION(msg) $display("%s", msg)
`endif
  logic [31:0] grant_cnt_q [REQUESTERS] `EXM_VLTOR_PUBLIC_RD;
  logic [31:0] wait_cnt_q  [REQUESTERS] `EXM_VLTOR_PUBLIC_RD;

  always_ff @(posedge mem_arb_clk_ip or posedge mem_arb_rst_ip) begin
    if (mem_arb_rst_ip) begin
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
        grant_cnt_q[k] <= '0;
        wait_cnt_q[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
        if (gnt[k] && (grant_cnt_q[k] != '1)) grant_cnt_q[k] <= grant_cnt_q[k] + 32'd1;
        if (bus.mem_arb_req_ip[k] && !gnt[k] && (wait_cnt_q[k] != '1)) begin
          wait_cnt_q[k] <= wait_cnt_q[k] + 32'd1;
        end
      end
    end
  end

  final begin
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      `EXM_INFORMATION($sformatf("mem_arb requester %0d grants %0d waits %0d",
                                 k, grant_cnt_q[k], wait_cnt_q[k]));
    end
  end
`endif
endmodule
